// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI4 channel bundles and arbiter types for the ysyx_24080006 core.
//   axi_r_m2s_t : read request  (AR channel + rready), master -> slave, 47 bits
//   axi_r_s2m_t : read response (arready + R channel), slave -> master, 35 bits
//   axi_w_m2s_t : write request (AW + W channels + bready), master -> slave, 85 bits
//   axi_w_s2m_t : write response (awready, wready, bvalid), slave -> master, 3 bits
package ysyx_24080006_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
  localparam logic [7:0] IFU_REFILL_LEN  = 8'd7;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU,
    OWNER_LSU
  } arb_owner_e;

endpackage

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Two-requester AXI4 arbiter: the IFU (read bursts) and the LSU (single-beat
// reads and writes) share one downstream master port. One transaction is in
// flight at a time; the granted requester owns the bus until its last R beat
// or its B response, and every other requester sees all-zero responses.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   ifu_r_i / ifu_r_o  : IFU read request / response
//   lsu_r_i / lsu_r_o  : LSU read request / response
//   lsu_w_i / lsu_w_o  : LSU write request / response
//   mem_r_o / mem_r_i  : downstream read request / response
//   mem_w_o / mem_w_i  : downstream write request / response
module ysyx_24080006_axi_arbiter
  import ysyx_24080006_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_r_m2s_t ifu_r_i,
  output axi_r_s2m_t ifu_r_o,
  input  axi_r_m2s_t lsu_r_i,
  output axi_r_s2m_t lsu_r_o,
  input  axi_w_m2s_t lsu_w_i,
  output axi_w_s2m_t lsu_w_o,
  output axi_r_m2s_t mem_r_o,
  input  axi_r_s2m_t mem_r_i,
  output axi_w_m2s_t mem_w_o,
  input  axi_w_s2m_t mem_w_i
);

  arb_state_e state;
  arb_owner_e owner;
  logic       last_ifu;
  logic       aw_done;
  logic       w_done;

  axi_r_m2s_t sel_r;
  axi_r_s2m_t rsp_r;
  logic       ar_fire;
  logic       r_last_fire;
  logic       aw_fire;
  logic       w_last_fire;
  logic       b_fire;

  // Output muxing: everything defaults to zero and only the owner's channels
  // of the current phase are connected through.
  always_comb begin
    sel_r   = (owner == OWNER_IFU) ? ifu_r_i : lsu_r_i;
    rsp_r   = '0;
    mem_r_o = '0;
    mem_w_o = '0;
    ifu_r_o = '0;
    lsu_r_o = '0;
    lsu_w_o = '0;

    unique case (state)
      RD_ADDR: begin
        mem_r_o.arvalid = sel_r.arvalid;
        mem_r_o.araddr  = sel_r.araddr;
        mem_r_o.arlen   = sel_r.arlen;
        mem_r_o.arsize  = sel_r.arsize;
        mem_r_o.arburst = sel_r.arburst;
        rsp_r.arready   = mem_r_i.arready;
      end
      RD_DATA: begin
        mem_r_o.rready = sel_r.rready;
        rsp_r.rvalid   = mem_r_i.rvalid;
        rsp_r.rdata    = mem_r_i.rdata;
        rsp_r.rlast    = mem_r_i.rlast;
      end
      WR_REQ: begin
        // A channel whose handshake already happened is muted so the slave
        // never sees a second AW or W from the same transaction.
        if (!aw_done) begin
          mem_w_o.awvalid = lsu_w_i.awvalid;
          mem_w_o.awaddr  = lsu_w_i.awaddr;
          mem_w_o.awlen   = lsu_w_i.awlen;
          mem_w_o.awsize  = lsu_w_i.awsize;
          mem_w_o.awburst = lsu_w_i.awburst;
          lsu_w_o.awready = mem_w_i.awready;
        end
        if (!w_done) begin
          mem_w_o.wvalid = lsu_w_i.wvalid;
          mem_w_o.wdata  = lsu_w_i.wdata;
          mem_w_o.wstrb  = lsu_w_i.wstrb;
          mem_w_o.wlast  = lsu_w_i.wlast;
          lsu_w_o.wready = mem_w_i.wready;
        end
      end
      WR_RESP: begin
        mem_w_o.bready = lsu_w_i.bready;
        lsu_w_o.bvalid = mem_w_i.bvalid;
      end
      default: ;
    endcase

    if (state == RD_ADDR || state == RD_DATA) begin
      if (owner == OWNER_IFU) begin
        ifu_r_o = rsp_r;
      end else begin
        lsu_r_o = rsp_r;
      end
    end

    ar_fire     = mem_r_o.arvalid & mem_r_i.arready;
    r_last_fire = mem_r_i.rvalid & mem_r_o.rready & mem_r_i.rlast;
    aw_fire     = mem_w_o.awvalid & mem_w_i.awready;
    w_last_fire = mem_w_o.wvalid & mem_w_i.wready & mem_w_o.wlast;
    b_fire      = mem_w_i.bvalid & mem_w_o.bready;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      owner    <= OWNER_IFU;
      last_ifu <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_w_i.awvalid) begin
            owner <= OWNER_LSU;
            state <= WR_REQ;
          end else if (ifu_r_i.arvalid || lsu_r_i.arvalid) begin
            // Contended reads alternate: the IFU yields only if it had the
            // previous read grant.
            if (ifu_r_i.arvalid && (!lsu_r_i.arvalid || !last_ifu)) begin
              owner    <= OWNER_IFU;
              last_ifu <= 1'b1;
            end else begin
              owner    <= OWNER_LSU;
              last_ifu <= 1'b0;
            end
            state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (ar_fire) begin
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_last_fire) begin
            state <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            aw_done <= 1'b1;
          end
          if (w_last_fire) begin
            w_done <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_last_fire)) begin
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_fire) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_24080006_axi_arbiter.md
# ysyx_24080006_axi_arbiter

Shares the single downstream AXI4 master port between the instruction fetch unit (icache line refills, read-only bursts) and the load/store unit (single-beat reads and writes). The block locks one requester onto the bus for an entire transaction and tracks burst and response completion. It forwards only that requester's channels and keeps every other requester's handshake signals low. It sits between the IFU/LSU and the SoC crossbar or simulation memory. At most one transaction is outstanding at a time.

## Interface
- No parameters. Burst length comes from the requester's `arlen`: IFU refill is `arlen` = 7, INCR, 4-byte beats; LSU uses `arlen` = 0.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `ifu_r_i` in `axi_r_m2s_t` (47): IFU read request.
- `ifu_r_o` out `axi_r_s2m_t` (35): IFU read response.
- `lsu_r_i` in `axi_r_m2s_t` (47): LSU read request.
- `lsu_r_o` out `axi_r_s2m_t` (35): LSU read response.
- `lsu_w_i` in `axi_w_m2s_t` (85): LSU write request.
- `lsu_w_o` out `axi_w_s2m_t` (3): LSU write response.
- `mem_r_o` out `axi_r_m2s_t` (47): downstream read request.
- `mem_r_i` in `axi_r_s2m_t` (35): downstream read response.
- `mem_w_o` out `axi_w_m2s_t` (85): downstream write request.
- `mem_w_i` in `axi_w_s2m_t` (3): downstream write response.

## Operation
- FSM states: `IDLE`, `RD_ADDR`, `RD_DATA`, `WR_REQ`, `WR_RESP`. Owner register is one of IFU or LSU. Round-robin bit `last_ifu` records whether the IFU got the last read grant.
- `IDLE` request sources:
  - A write request is `lsu_w_i.awvalid`.
  - A read request is `ifu_r_i.arvalid` or `lsu_r_i.arvalid`.
- `IDLE` arbitration order:
  - An LSU write wins over any read and moves the FSM to `WR_REQ`.
  - Otherwise, with one read requester, that requester wins.
  - With both read requesters, LSU wins if `last_ifu` = 1, else IFU wins.
  - After a read grant, update `last_ifu` and move to `RD_ADDR`.
- `RD_ADDR`: `mem_r_o` follows the owner's `arvalid`/`araddr`/`arlen`/`arsize`/`arburst`. The owner's `arready` follows `mem_r_i.arready`. On the AR handshake, move to `RD_DATA`.
- `RD_DATA`:
  - `mem_r_o.rready` follows the owner's `rready`.
  - The owner sees `rvalid`/`rdata`/`rlast` from `mem_r_i`.
  - On a beat handshake with `rlast` = 1, move to `IDLE`.
  - Beats without `rlast` keep the FSM in `RD_DATA`. The arbiter does not count beats.
- `WR_REQ`:
  - AW and W complete independently. Sticky flags `aw_done` and `w_done` block further `awvalid`/`wvalid` for their channel once set.
  - The state exits only after both the AW handshake and a W handshake with `wlast` have occurred, in any order or in the same cycle. It then moves to `WR_RESP`.
- `WR_RESP`: `bready` and `bvalid` pass through. On the B handshake, move to `IDLE` and clear the flags.
- Non-owner outputs (and all requester outputs in `IDLE`): `arready`, `rvalid`, `rlast`, `awready`, `wready` and `bvalid` are 0, and `rdata` is 0.
- `mem_*_o` outside the owning phase: all valid and ready bits are 0. Address, data and control fields are 0.
- Requesters hold `arvalid`/`awvalid`/`wvalid` until their handshake. Dropping one early is a protocol violation. The arbiter does not guard against it.

## Timing
- Reset (`rst_ni` = 0 at a rising edge): FSM goes to `IDLE`, `last_ifu` = 0, `aw_done` and `w_done` = 0. Every output bit is 0 in the following cycle.
- Reset mid-transaction abandons the transaction. Downstream is reset together with the arbiter.
- Arbitration latency: a request seen in `IDLE` in cycle N appears on `mem_*_o` in cycle N+1. The downstream AR/AW path is registered through the state. The data, ready and response paths are combinational pass-through.
- Return to `IDLE` in cycle N+1 after the last handshake. The earliest next grant is in cycle N+1, with output in N+2. There is one bubble cycle between transactions.
- Simultaneous new requests arriving while busy wait without a handshake. They are re-evaluated only in `IDLE`.
- Minimum IFU refill with a zero-wait slave: 1 (grant) + 1 (AR) + 8 (R) = 10 cycles.

## Structure
- Reuse `axi_r_m2s_t`, `axi_r_s2m_t`, `axi_w_m2s_t` and `axi_w_s2m_t` from `ysyx_24080006_pkg`.
- Add `arb_state_e` (the five states) and `arb_owner_e` (`OWNER_IFU`, `OWNER_LSU`) to the package.
- Single module, no sub-modules. Muxing is a small always_comb keyed on state and owner.

## Test plan
- IFU burst alone: `ifu` `araddr` = 0x3000_0040, `arlen` = 7 → one downstream AR with the same fields. Eight beats reach the IFU, `rlast` on beat 8. The LSU sees `rvalid` = 0 throughout. The FSM is back in `IDLE` one cycle after the last beat.
- Concurrent reads from reset: IFU and LSU assert `arvalid` in the same cycle → IFU is granted first (`last_ifu` = 0), then the LSU. With both re-requesting, grants alternate IFU, LSU, IFU, LSU.
- LSU write with split channels: AW handshake in cycle 3, W (`wdata` = 0xDEAD_BEEF, `wstrb` = 0xF, `wlast` = 1) in cycle 6 → `awvalid` stays low after cycle 3. The FSM enters `WR_RESP` at cycle 7 and returns to `IDLE` after `bvalid`.
- Write versus read: LSU `awvalid` and IFU `arvalid` in the same `IDLE` cycle → the write is granted first. The IFU AR is issued only after the B handshake plus one cycle.
- Mid-burst contention: the LSU requests during beat 3 of an IFU burst → no LSU `arready` until the IFU `rlast`. The LSU is granted at the next `IDLE`.
- Reset in `RD_DATA` at beat 4 → the next cycle shows all outputs 0 and the FSM in `IDLE`. A fresh LSU read then completes normally.
